regfile_sb: RTL
===============

// Module: regfile_sb
// PURPOSE
//  Parametrised successor to the core's 2-read/1-write register file. Adds N read ports,
//  optional write-to-read bypass and a per-register busy scoreboard for multi-cycle producers.
//  Sits between decode (issue/read) and writeback in the rv32i datapath.
// PARAMETERS
//  XLEN           32   data width
//  NUM_REGS       32   architectural registers (power of 2, >=2)
//  REG_ADDR_WIDTH $clog2(NUM_REGS)  address width
//  NUM_RD_PORTS   2    independent read ports (1..4)
//  BYPASS         1    1: same-cycle write data forwarded to matching reads; 0: old value read
//  ZERO_REG       1    1: register 0 hardwired to 0, never busy
// PORTS
//  clk        in   1                          clock, rising edge
//  rst        in   1                          synchronous, active-high reset
//  rd_addr    in   NUM_RD_PORTS*REG_ADDR_WIDTH  read addresses, port p at [p*AW +: AW]
//  rd_data    out  NUM_RD_PORTS*XLEN          read data, port p at [p*XLEN +: XLEN]
//  rd_busy    out  NUM_RD_PORTS               read register has pending producer
//  wr_en      in   1                          writeback strobe
//  wr_addr    in   REG_ADDR_WIDTH             writeback address
//  wr_data    in   XLEN                       writeback data
//  issue_en   in   1                          request: mark issue_addr busy
//  issue_addr in   REG_ADDR_WIDTH             destination of issuing instruction
//  issue_ok   out  1                          issue accepted this cycle
//  flush      in   1                          clear all busy bits (pipeline flush)
//  busy_cnt   out  REG_ADDR_WIDTH+1           number of busy registers
// BEHAVIOUR
//  Reset: all registers <= 0, all busy bits <= 0, busy_cnt = 0; held while rst=1,
//   wr_en/issue_en ignored; reset mid-operation discards pending writes/issues.
//  Reads: combinational, zero latency. Reg 0 reads 0 when ZERO_REG=1.
//  Bypass (BYPASS=1): wr_en && wr_addr==rd_addr && !(ZERO_REG && addr==0) -> rd_data=wr_data,
//   rd_busy=0 for that port. BYPASS=0: rd_data=stored value, rd_busy=busy bit.
//  Write: on clk edge with wr_en, reg[wr_addr]<=wr_data (dropped for reg 0 if ZERO_REG);
//   busy[wr_addr]<=0. Writes to non-busy regs are legal (plain update).
//  Issue: issue_ok = issue_en && !rst && !flush && (busy[issue_addr]==0 || wr_en&&wr_addr==issue_addr).
//   issue_ok -> busy[issue_addr]<=1 next edge. Issue to reg 0 (ZERO_REG=1): issue_ok=1, no bit set.
//   Busy target with no same-cycle write -> issue_ok=0 (WAW stall), state unchanged.
//  Simultaneous write+issue same addr: data written, busy ends SET (new producer wins).
//  Flush: all busy<=0 next edge; register contents unaffected; a same-cycle write still lands.
//   Flush has priority over issue; issue_ok=0 during flush.
//  busy_cnt: registered popcount of busy bits, updated same edge as bits; range 0..NUM_REGS.
//  Multiple read ports may address the same register; all return identical values.
// TESTING
//  1 Reset, read all ports addr 0..31 -> all rd_data=0, rd_busy=0, busy_cnt=0.
//  2 wr x1=20, x2=30; read p0=1,p1=2 next cycle -> 20/30; wr x0=20 -> x0 still reads 0.
//  3 BYPASS=1: wr_en x5=0xDEAD with rd_addr p0=5 same cycle -> rd_data=0xDEAD, rd_busy=0;
//    BYPASS=0 build -> old value 0.
//  4 issue x3 -> busy_cnt=1, rd_busy(x3)=1; reissue x3 -> issue_ok=0; wr x3=7 + issue x3
//    same cycle -> issue_ok=1, x3=7, busy stays 1, busy_cnt=1.
//  5 issue x4,x6,x7 -> busy_cnt=3; flush -> busy_cnt=0, x4/x6/x7 values unchanged; issue during
//    flush -> issue_ok=0.
//  6 rst asserted with busy_cnt=2 and wr_en pending -> next edge all regs 0, busy_cnt=0, write lost.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Bus bundle between decode/writeback and the scoreboarded register file.
// "master" is the pipeline side and "slave" is the register file.
interface regfile_sb_if #(
   parameter int XLEN           = 32,
   parameter int NUM_REGS       = 32,
   parameter int REG_ADDR_WIDTH = $clog2(NUM_REGS),
   parameter int NUM_RD_PORTS   = 2
);
   logic [NUM_RD_PORTS*REG_ADDR_WIDTH-1:0] rd_addr;
   logic [NUM_RD_PORTS*XLEN-1:0]           rd_data;
   logic [NUM_RD_PORTS-1:0]                rd_busy;
   logic                                   wr_en;
   logic [REG_ADDR_WIDTH-1:0]              wr_addr;
   logic [XLEN-1:0]                        wr_data;
   logic                                   issue_en;
   logic [REG_ADDR_WIDTH-1:0]              issue_addr;
   logic                                   issue_ok;
   logic                                   flush;
   logic [REG_ADDR_WIDTH:0]                busy_cnt;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
      input  rd_data, rd_busy, issue_ok, busy_cnt
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
      output rd_data, rd_busy, issue_ok, busy_cnt
   );
endinterface

// File: rtl/regfile_sb.sv
// Multi-port register file with optional write-to-read bypass and a per-register
// busy scoreboard tracking outstanding multi-cycle producers.
module regfile_sb #(
   parameter int XLEN           = 32,
   parameter int NUM_REGS       = 32,
   parameter int REG_ADDR_WIDTH = $clog2(NUM_REGS),
   parameter int NUM_RD_PORTS   = 2,
   parameter int BYPASS         = 1,
   parameter int ZERO_REG       = 1
) (
   input  logic         clk,
   input  logic         rst,
   regfile_sb_if.slave  bus
);
   localparam int AW = REG_ADDR_WIDTH;

   logic [XLEN-1:0]     regs [NUM_REGS];
   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_nxt;
   logic [AW:0]         busy_cnt_q;
   logic                issue_ok_c;
   logic                issue_zero;
   logic                wr_zero;

   logic [NUM_RD_PORTS*XLEN-1:0] rd_data_c;
   logic [NUM_RD_PORTS-1:0]      rd_busy_c;
   logic [AW-1:0]                rd_a;
   logic                         rd_zero;
   logic                         rd_byp;

   function automatic logic [AW:0] popcount(input logic [NUM_REGS-1:0] v);
      logic [AW:0] c;
      c = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         c = c + {{AW{1'b0}}, v[i]};
      end
      return c;
   endfunction

   // A write to the issue target in the same cycle frees the slot for the new producer.
   always_comb begin
      issue_zero = (ZERO_REG != 0) && (bus.issue_addr == '0);
      wr_zero    = (ZERO_REG != 0) && (bus.wr_addr == '0);
      issue_ok_c = bus.issue_en && !rst && !bus.flush &&
                   (!busy[bus.issue_addr] ||
                    (bus.wr_en && (bus.wr_addr == bus.issue_addr)));
      busy_nxt = busy;
      if (bus.wr_en) begin
         busy_nxt[bus.wr_addr] = 1'b0;
      end
      if (issue_ok_c && !issue_zero) begin
         busy_nxt[bus.issue_addr] = 1'b1;
      end
      if (bus.flush) begin
         busy_nxt = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
         busy       <= '0;
         busy_cnt_q <= '0;
      end else begin
         if (bus.wr_en && !wr_zero) begin
            regs[bus.wr_addr] <= bus.wr_data;
         end
         busy       <= busy_nxt;
         busy_cnt_q <= popcount(busy_nxt);
      end
   end

   always_comb begin
      rd_data_c = '0;
      rd_busy_c = '0;
      rd_a      = '0;
      rd_zero   = 1'b0;
      rd_byp    = 1'b0;
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
         rd_a    = bus.rd_addr[p*AW +: AW];
         rd_zero = (ZERO_REG != 0) && (rd_a == '0);
         rd_byp  = (BYPASS != 0) && bus.wr_en && (bus.wr_addr == rd_a) && !rd_zero;
         if (rd_zero) begin
            rd_data_c[p*XLEN +: XLEN] = '0;
            rd_busy_c[p]              = 1'b0;
         end else if (rd_byp) begin
            rd_data_c[p*XLEN +: XLEN] = bus.wr_data;
            rd_busy_c[p]              = 1'b0;
         end else begin
            rd_data_c[p*XLEN +: XLEN] = regs[rd_a];
            rd_busy_c[p]              = busy[rd_a];
         end
      end
   end

   assign bus.rd_data  = rd_data_c;
   assign bus.rd_busy  = rd_busy_c;
   assign bus.issue_ok = issue_ok_c;
   assign bus.busy_cnt = busy_cnt_q;
endmodule
